axi_wdata_router: RTL and testbench
===================================

Name: axi_wdata_router

Overview:
- Parametrised AXI write-data crossbar stage between NUM_M masters and NUM_S slaves, placed after the write-address arbiter in the bus interconnect.
- Each accepted AW handshake pushes a route entry {master, slave, awlen} into an in-order queue. W beats are steered from the head entry's master to its slave.
- Adds what the previous generation lacked: multiple outstanding writes, a beat counter that enforces WLAST, and a sink for unmapped slaves.

Parameters:
NUM_M, 2, number of write masters
NUM_S, 6, number of write slaves; slave index >= NUM_S is unmapped
DATA_W, 32, W data width; STRB_W = DATA_W/8
LEN_W, 4, AWLEN width; bursts are 1..2^LEN_W beats
DEPTH, 4, outstanding-write queue depth (power of 2, >= 2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
aw_push_valid  in  1  AW handshake completed at a slave; route entry offered
aw_push_ready  out  1  queue can accept an entry (= not full)
aw_push_mst  in  $clog2(NUM_M)  issuing master index
aw_push_slv  in  $clog2(NUM_S+1)  decoded slave index; value NUM_S means unmapped
aw_push_len  in  LEN_W  AWLEN
m_wdata  in  NUM_M*DATA_W  master W data, packed
m_wstrb  in  NUM_M*STRB_W  master W strobes
m_wlast  in  NUM_M  master WLAST
m_wvalid  in  NUM_M  master WVALID
m_wready  out  NUM_M  master WREADY
s_wdata  out  NUM_S*DATA_W  slave W data
s_wstrb  out  NUM_S*STRB_W  slave W strobes
s_wlast  out  NUM_S  slave WLAST, counter-derived
s_wvalid  out  NUM_S  slave WVALID
s_wready  in  NUM_S  slave WREADY
err_wlast  out  1  one-cycle pulse: master WLAST disagreed with the beat count
err_unmapped  out  1  one-cycle pulse: a burst to an unmapped slave was drained
busy  out  1  queue not empty

Behaviour:
- Reset (sync, active-high): queue empty, beat counter 0, err pulses 0. All m_wready and s_wvalid are 0. s_wstrb are all-ones and s_wdata/s_wlast are 0 while idle. aw_push_ready is 1 from the first cycle after reset. A reset mid-burst drops every queued entry.
- Push: occurs when aw_push_valid && aw_push_ready. There is no full-bypass: when full, aw_push_ready=0 even if a pop happens in the same cycle.
- No empty-bypass: an entry pushed in cycle N can route W beats from cycle N+1 at the earliest. While empty, all m_wready=0 and all s_wvalid=0.
- Routing (combinational, zero added latency) with head entry {h_m, h_s, h_len} valid:
  - s_wvalid[h_s] = m_wvalid[h_m]; data and strobes pass straight through.
  - m_wready[h_m] = s_wready[h_s].
  - All other m_wready and s_wvalid are 0. s_wstrb for non-selected slaves is all-ones.
- Beat counter: cnt increments on each handshake of the head burst.
  - s_wlast[h_s] = (cnt == h_len), irrespective of the master's WLAST.
  - On the last handshake, pop the head and clear cnt. The next entry routes in the following cycle.
  - Simultaneous push and pop with a non-full queue: both occur; occupancy is unchanged.
- WLAST check, on any head handshake: if m_wlast[h_m] != (cnt == h_len), pulse err_wlast for one cycle. Routing still follows the counter.
- Unmapped head (h_s >= NUM_S):
  - m_wready[h_m] = 1 and no slave is driven; beats are consumed and dropped.
  - err_unmapped pulses on the final beat's handshake.
- Pointers are $clog2(DEPTH) wide with an extra wrap bit. Full means indices are equal and wrap bits differ.
- Only the head master is served; other masters' W beats wait (no interleaving, AXI4 order).

Decomposition:
- Shared package axi_wr_pkg holds:
  - route_entry_t struct {mst, slv, len}
  - localparams MIDX_W=$clog2(NUM_M), SIDX_W=$clog2(NUM_S+1)
  - the UNMAPPED constant = NUM_S
- One sub-module, axi_route_fifo: parametrised synchronous FIFO (DEPTH, route_entry_t) with push/pop/full/empty and the head entry exposed. The top level holds the counter, the mux/demux and the error logic.

Test Plan:
- Push {m1,s2,len=3}; m1 streams 4 beats with s_wready=1 -> s_wvalid[2] high for 4 cycles; s_wlast[2] only on beat 4; pop; busy drops the cycle after.
- Push {m0,s1,0} then {m1,s5,1}; both masters valid -> m0's single beat goes to s1 first, then m1's 2 beats to s5; m_wready[1]=0 during the m0 beat.
- Push 4 entries with no W traffic -> aw_push_ready=0 after the 4th. Complete one burst -> ready returns the next cycle; a 5th push in the pop cycle is refused.
- Entry {m0,s3,len=1}; m0 asserts WLAST on beat 1 -> err_wlast pulses at beat 1; burst still ends at beat 2 with s_wlast[3]=1.
- Entry {m1,slv=6 (unmapped),len=2} -> m_wready[1]=1 for 3 beats, all s_wvalid=0, err_unmapped pulses on beat 3.
- Assert rst mid-burst (after beat 2 of len=7) -> next cycle queue empty, all s_wvalid/m_wready=0, aw_push_ready=1.

Source files
------------

// File: rtl/axi_wr_pkg.sv
// Shared sizing and route-entry layout for the AXI write-data router.
// Master/slave counts and the AWLEN width live here, so every block sees one entry format.
package axi_wr_pkg;

  localparam int NUM_M  = 2;
  localparam int NUM_S  = 6;
  localparam int LEN_W  = 4;
  localparam int MIDX_W = $clog2(NUM_M);
  localparam int SIDX_W = $clog2(NUM_S + 1);

  // A decoded slave index equal to NUM_S marks an address with no slave behind it.
  localparam logic [SIDX_W-1:0] UNMAPPED = SIDX_W'(NUM_S);

  typedef struct packed {
    logic [MIDX_W-1:0] mst;
    logic [SIDX_W-1:0] slv;
    logic [LEN_W-1:0]  len;
  } route_entry_t;

  function automatic logic slv_is_mapped(input logic [SIDX_W-1:0] slv);
    return slv < UNMAPPED;
  endfunction

endpackage

// File: rtl/axi_wdata_router_if.sv
// Bus bundle between the write-address arbiter, the W masters/slaves and the data router.
// The router sits on the slave modport; the surrounding fabric drives the master modport.
interface axi_wdata_router_if #(
  parameter int DATA_W = 32
);
  import axi_wr_pkg::*;

  localparam int STRB_W = DATA_W / 8;

  // Every valid/ready pair transfers on a cycle where both are high at the rising edge;
  // valid never waits on ready, and a master holds its beat stable until it is taken.
  logic                     aw_push_valid;
  logic                     aw_push_ready;
  logic [MIDX_W-1:0]        aw_push_mst;
  logic [SIDX_W-1:0]        aw_push_slv;
  logic [LEN_W-1:0]         aw_push_len;

  logic [NUM_M*DATA_W-1:0]  m_wdata;
  logic [NUM_M*STRB_W-1:0]  m_wstrb;
  logic [NUM_M-1:0]         m_wlast;
  logic [NUM_M-1:0]         m_wvalid;
  logic [NUM_M-1:0]         m_wready;

  logic [NUM_S*DATA_W-1:0]  s_wdata;
  logic [NUM_S*STRB_W-1:0]  s_wstrb;
  logic [NUM_S-1:0]         s_wlast;
  logic [NUM_S-1:0]         s_wvalid;
  logic [NUM_S-1:0]         s_wready;

  logic                     err_wlast;
  logic                     err_unmapped;
  logic                     busy;

  modport master (
    output aw_push_valid, aw_push_mst, aw_push_slv, aw_push_len,
    output m_wdata, m_wstrb, m_wlast, m_wvalid, s_wready,
    input  aw_push_ready, m_wready, s_wdata, s_wstrb, s_wlast, s_wvalid,
    input  err_wlast, err_unmapped, busy
  );

  modport slave (
    input  aw_push_valid, aw_push_mst, aw_push_slv, aw_push_len,
    input  m_wdata, m_wstrb, m_wlast, m_wvalid, s_wready,
    output aw_push_ready, m_wready, s_wdata, s_wstrb, s_wlast, s_wvalid,
    output err_wlast, err_unmapped, busy
  );

endinterface

// File: rtl/axi_route_fifo.sv
// In-order queue of outstanding write routes; the head entry steers the W channel.
// Pointers carry one extra wrap bit so full and empty are told apart without a counter.
module axi_route_fifo
  import axi_wr_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = route_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push_i,
  input  entry_t entry_i,
  input  logic   pop_i,
  output logic   full_o,
  output logic   empty_o,
  output entry_t head_o
);

  localparam int AW = $clog2(DEPTH);

  entry_t      mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Full refuses a push even when the head pops this cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= entry_i;
  end

endmodule

// File: rtl/axi_wdata_router.sv
// W-channel crossbar stage: steers beats from the head route's master to its slave,
// terminates bursts by beat count, and sinks bursts aimed at unmapped addresses.
module axi_wdata_router
  import axi_wr_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input logic               clk,
  input logic               rst,
  axi_wdata_router_if.slave bus
);

  localparam int STRB_W = DATA_W / 8;

  route_entry_t      push_entry;
  route_entry_t      head;
  logic              q_full, q_empty, q_pop;
  logic              head_mapped, last_beat, beat_hs;
  logic              sel_wvalid, sel_wlast, sel_sready;
  logic [DATA_W-1:0] sel_wdata;
  logic [STRB_W-1:0] sel_wstrb;
  logic [LEN_W-1:0]  cnt_q, cnt_d;

  assign push_entry = '{mst: bus.aw_push_mst, slv: bus.aw_push_slv, len: bus.aw_push_len};

  axi_route_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (route_entry_t)
  ) u_route_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (bus.aw_push_valid),
    .entry_i (push_entry),
    .pop_i   (q_pop),
    .full_o  (q_full),
    .empty_o (q_empty),
    .head_o  (head)
  );

  assign bus.aw_push_ready = ~q_full;
  assign bus.busy          = ~q_empty;
  assign head_mapped       = slv_is_mapped(head.slv);
  assign last_beat         = (cnt_q == head.len);

  always_comb begin
    sel_wvalid = 1'b0;
    sel_wlast  = 1'b0;
    sel_wdata  = '0;
    sel_wstrb  = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (head.mst == MIDX_W'(i)) begin
        sel_wvalid = bus.m_wvalid[i];
        sel_wlast  = bus.m_wlast[i];
        sel_wdata  = bus.m_wdata[i*DATA_W +: DATA_W];
        sel_wstrb  = bus.m_wstrb[i*STRB_W +: STRB_W];
      end
    end
  end

  // An unmapped head matches no slave, so the default makes it an always-ready sink.
  always_comb begin
    sel_sready = 1'b1;
    for (int j = 0; j < NUM_S; j++) begin
      if (head.slv == SIDX_W'(j)) sel_sready = bus.s_wready[j];
    end
  end

  assign beat_hs = ~q_empty & sel_wvalid & sel_sready;
  assign q_pop   = beat_hs & last_beat;

  always_comb begin
    bus.m_wready = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (!q_empty && head.mst == MIDX_W'(i)) bus.m_wready[i] = sel_sready;
    end
  end

  always_comb begin
    bus.s_wvalid = '0;
    bus.s_wlast  = '0;
    bus.s_wdata  = '0;
    bus.s_wstrb  = '1;
    for (int j = 0; j < NUM_S; j++) begin
      if (!q_empty && head.slv == SIDX_W'(j)) begin
        bus.s_wvalid[j]                  = sel_wvalid;
        bus.s_wlast[j]                   = last_beat;
        bus.s_wdata[j*DATA_W +: DATA_W]  = sel_wdata;
        bus.s_wstrb[j*STRB_W +: STRB_W]  = sel_wstrb;
      end
    end
  end

  // Burst length comes from AWLEN, never from the master's WLAST.
  always_comb begin
    cnt_d = cnt_q;
    if (beat_hs) cnt_d = last_beat ? '0 : cnt_q + LEN_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign bus.err_wlast    = beat_hs & (sel_wlast != last_beat);
  assign bus.err_unmapped = q_pop & ~head_mapped;

endmodule

// File: tb/tb_axi_wdata_router.sv
// Bench for axi_wdata_router: directed bursts plus random traffic, every cycle checked
// against a queue-of-routes model that tracks beats taken on the head burst.
module tb_axi_wdata_router;
  import axi_wr_pkg::*;

  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam int DEPTH  = 4;
  localparam int EW     = $bits(route_entry_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_wdata_router_if #(.DATA_W(DATA_W)) bus ();

  axi_wdata_router #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard state ----------------
  int            checks = 0;
  int            errors = 0;
  logic [EW-1:0] exp_q[$];
  int            beats_done;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    route_entry_t            h;
    logic [NUM_M-1:0]        e_mready;
    logic [NUM_S-1:0]        e_svalid, e_slast;
    logic [NUM_S*DATA_W-1:0] e_sdata;
    logic [NUM_S*STRB_W-1:0] e_sstrb;
    logic                    e_err_wlast, e_err_unm, hs, last, unm;
    e_mready = '0; e_svalid = '0; e_slast = '0; e_sdata = '0; e_sstrb = '1;
    e_err_wlast = 1'b0; e_err_unm = 1'b0;
    if (exp_q.size() != 0) begin
      h    = route_entry_t'(exp_q[0]);
      unm  = (int'(h.slv) >= NUM_S);
      last = (beats_done == int'(h.len));
      e_mready[h.mst] = unm ? 1'b1 : bus.s_wready[h.slv];
      if (!unm) begin
        e_svalid[h.slv] = bus.m_wvalid[h.mst];
        e_slast[h.slv]  = last;
        e_sdata[int'(h.slv)*DATA_W +: DATA_W] = bus.m_wdata[int'(h.mst)*DATA_W +: DATA_W];
        e_sstrb[int'(h.slv)*STRB_W +: STRB_W] = bus.m_wstrb[int'(h.mst)*STRB_W +: STRB_W];
      end
      hs          = bus.m_wvalid[h.mst] && e_mready[h.mst];
      e_err_wlast = hs && (bus.m_wlast[h.mst] != last);
      e_err_unm   = hs && last && unm;
    end
    check_eq("aw_push_ready", 256'(bus.aw_push_ready), 256'(exp_q.size() < DEPTH));
    check_eq("busy",          256'(bus.busy),          256'(exp_q.size() != 0));
    check_eq("m_wready",      256'(bus.m_wready),      256'(e_mready));
    check_eq("s_wvalid",      256'(bus.s_wvalid),      256'(e_svalid));
    check_eq("s_wlast",       256'(bus.s_wlast),       256'(e_slast));
    check_eq("s_wdata",       256'(bus.s_wdata),       256'(e_sdata));
    check_eq("s_wstrb",       256'(bus.s_wstrb),       256'(e_sstrb));
    check_eq("err_wlast",     256'(bus.err_wlast),     256'(e_err_wlast));
    check_eq("err_unmapped",  256'(bus.err_unmapped),  256'(e_err_unm));
  endtask

  // Advance the model across one rising edge using the inputs that were applied.
  task automatic model_update();
    route_entry_t h;
    logic         can_push, unm;
    if (rst) begin
      exp_q.delete();
      beats_done = 0;
    end else begin
      can_push = (exp_q.size() < DEPTH);
      if (exp_q.size() != 0) begin
        h   = route_entry_t'(exp_q[0]);
        unm = (int'(h.slv) >= NUM_S);
        if (bus.m_wvalid[h.mst] && (unm || bus.s_wready[h.slv])) begin
          beats_done++;
          if (beats_done == int'(h.len) + 1) begin
            void'(exp_q.pop_front());
            beats_done = 0;
          end
        end
      end
      if (bus.aw_push_valid && can_push)
        exp_q.push_back({bus.aw_push_mst, bus.aw_push_slv, bus.aw_push_len});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    #3;
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < NUM_M; i++) begin
      bus.m_wdata[i*DATA_W +: DATA_W] = $urandom();
      bus.m_wstrb[i*STRB_W +: STRB_W] = STRB_W'($urandom());
    end
  endtask

  task automatic offer(input int m, input int s, input int len);
    bus.aw_push_valid = 1'b1;
    bus.aw_push_mst   = MIDX_W'(m);
    bus.aw_push_slv   = SIDX_W'(s);
    bus.aw_push_len   = LEN_W'(len);
  endtask

  task automatic no_offer();
    bus.aw_push_valid = 1'b0;
  endtask

  task automatic idle_inputs();
    no_offer();
    bus.aw_push_mst = '0;
    bus.aw_push_slv = '0;
    bus.aw_push_len = '0;
    bus.m_wvalid    = '0;
    bus.m_wlast     = '0;
    bus.s_wready    = '1;
    rand_data();
  endtask

  // Master m presents n beats; WLAST is right on the final beat and also forced at bad_beat.
  task automatic stream(input int m, input int n, input int bad_beat);
    for (int k = 0; k < n; k++) begin
      rand_data();
      bus.m_wvalid    = '0;
      bus.m_wvalid[m] = 1'b1;
      bus.m_wlast     = '0;
      bus.m_wlast[m]  = (k == n - 1) || (k == bad_beat);
      cycle();
      no_offer();
    end
    bus.m_wvalid = '0;
    bus.m_wlast  = '0;
  endtask

  task automatic drive_good_last();
    route_entry_t h;
    if (exp_q.size() != 0) begin
      h = route_entry_t'(exp_q[0]);
      bus.m_wlast[h.mst] = (beats_done == int'(h.len));
    end
  endtask

  task automatic drain();
    int budget = 200;
    no_offer();
    bus.s_wready = '1;
    while (exp_q.size() != 0 && budget > 0) begin
      rand_data();
      bus.m_wvalid = '1;
      bus.m_wlast  = '0;
      drive_good_last();
      cycle();
      budget--;
    end
    bus.m_wvalid = '0;
    bus.m_wlast  = '0;
    check_eq("drain_busy", 256'(bus.busy), 256'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    beats_done = 0;
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    cycle();
    rst = 1'b0;
    cycle();

    // Single 4-beat burst m1 -> s2
    offer(1, 2, 3); cycle(); no_offer();
    stream(1, 4, -1);
    cycle(); cycle();

    // Two queued bursts with both masters requesting; m0's burst goes first
    offer(0, 1, 0); cycle();
    offer(1, 5, 1); cycle(); no_offer();
    for (int k = 0; k < 3; k++) begin
      rand_data();
      bus.m_wvalid = '1;
      bus.m_wlast  = '0;
      drive_good_last();
      cycle();
    end
    bus.m_wvalid = '0;
    cycle();

    // Fill the queue, then pop while a fifth entry is offered
    for (int k = 0; k < 4; k++) begin
      offer(0, k, 0); cycle();
    end
    no_offer(); cycle();
    offer(1, 0, 0);
    bus.m_wvalid[0] = 1'b1;
    bus.m_wlast[0]  = 1'b1;
    cycle();
    no_offer();
    bus.m_wvalid = '0;
    bus.m_wlast  = '0;
    cycle();
    offer(1, 5, 0); cycle();
    drain();

    // Early WLAST from m0 on a 2-beat burst to s3
    offer(0, 3, 1); cycle(); no_offer();
    stream(0, 2, 0);
    cycle();

    // Burst to the unmapped slave index is sunk
    offer(1, NUM_S, 2); cycle(); no_offer();
    stream(1, 3, -1);
    cycle();

    // Reset in the middle of an 8-beat burst
    offer(0, 4, 7); cycle(); no_offer();
    stream(0, 2, -1);
    bus.m_wvalid[0] = 1'b1;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    bus.m_wvalid = '0;
    cycle(); cycle();

    // Random traffic with back-pressure, stray WLAST and occasional reset
    for (int c = 0; c < 2000; c++) begin
      int len;
      rand_data();
      bus.s_wready = NUM_S'($urandom());
      bus.m_wvalid = NUM_M'($urandom());
      bus.m_wlast  = NUM_M'($urandom());
      if ($urandom_range(0, 7) != 0) drive_good_last();
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 2));
      if ($urandom_range(0, 2) == 0)
        offer(int'($urandom_range(0, NUM_M - 1)), int'($urandom_range(0, NUM_S)), len);
      else
        no_offer();
      rst = ($urandom_range(0, 299) == 0);
      cycle();
    end
    rst = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
